instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 51 +++++
 rtl/instr_mem_loader.sv | 155 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
// Stream format: 16-bit little-endian word count, then 4 bytes per word, LSB first.
package loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
   localparam int LEN_W          = 16;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      DONE_S,
      ERR
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into words, LSB first; word_dat/word_rdy are combinational on the 4th byte.
// No backpressure: every valid byte is accepted; clr discards any partial word.
module word_assembler
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BYTE_W-1:0] byte_dat,
   input  logic              byte_vld,
   input  logic              clr,
   output logic [WORD_W-1:0] word_dat,
   output logic              word_rdy
);

   logic [WORD_W-1:0] acc_q, acc_d;
   logic [BCNT_W-1:0] cnt_q, cnt_d;
   logic [WORD_W-1:0] merged;

   always_comb begin
      merged = acc_q;
      merged[cnt_q*BYTE_W +: BYTE_W] = byte_dat;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      word_rdy = 1'b0;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (byte_vld) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
            // The completed word leaves through word_dat this cycle, so start fresh.
            word_rdy = 1'b1;
            acc_d    = '0;
         end else begin
            acc_d = merged;
         end
      end
      word_dat = merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM, holding the CPU in reset meanwhile.
// WE pulses one cycle after the 4th byte of a word; no backpressure, a stalled stream just waits.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MEM_DEPTH = 256
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              BYTE_VALID,
   input  logic [7:0]        BYTE_DATA,
   output logic              WE,
   output logic [WIDTH-1:0]  WADDR,
   output logic [WIDTH-1:0]  WDATA,
   output logic              CPU_HOLD,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERROR
);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   widx_q, widx_d;
   logic               we_q, we_d;
   logic [WIDTH-1:0]   waddr_q, waddr_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic               hold_q, hold_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               asm_vld;
   logic               asm_clr;
   logic [WORD_W-1:0]  asm_word;
   logic               asm_rdy;
   logic [LEN_W-1:0]   len_full;

   assign asm_vld  = BYTE_VALID && (state_q == DATA);
   assign asm_clr  = (state_q != DATA);
   assign len_full = {BYTE_DATA, len_q[BYTE_W-1:0]};

   word_assembler u_word_assembler (
      .clk      (CLK),
      .rst_n    (RST),
      .byte_dat (BYTE_DATA),
      .byte_vld (asm_vld),
      .clr      (asm_clr),
      .word_dat (asm_word),
      .word_rdy (asm_rdy)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = LEN_LO;
               hold_d  = 1'b1;
            end
         end
         LEN_LO: begin
            if (BYTE_VALID) begin
               len_d   = LEN_W'(BYTE_DATA);
               state_d = LEN_HI;
            end
         end
         LEN_HI: begin
            if (BYTE_VALID) begin
               len_d  = len_full;
               widx_d = '0;
               if (len_full == '0) begin
                  state_d = DONE_S;
               end else if (int'(len_full) > MEM_DEPTH) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (asm_rdy) begin
               we_d    = 1'b1;
               waddr_d = WIDTH'(widx_q) << BCNT_W;
               wdata_d = WIDTH'(asm_word);
            end
            // The index advances during the WE cycle; the last write ends the load.
            if (we_q) begin
               widx_d = widx_q + 1'b1;
               if (widx_q == len_q - 1'b1) begin
                  state_d = DONE_S;
               end
            end
         end
         DONE_S: begin
            state_d = IDLE;
            hold_d  = 1'b0;
         end
         ERR: begin
            if (START) begin
               state_d = LEN_LO;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = 1'b0;
         end
      endcase
      busy_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
      done_d = (state_d == DONE_S);
      err_d  = (state_d == ERR);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         len_q   <= '0;
         widx_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign WE       = we_q;
   assign WADDR    = waddr_q;
   assign WDATA    = wdata_q;
   assign CPU_HOLD = hold_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERROR    = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a stream-level model queues expected RAM writes,
// and a negedge monitor pops and compares them whenever WE is seen.
module tb_instr_mem_loader;

   localparam int WIDTH     = 32;
   localparam int MEM_DEPTH = 256;

   logic             CLK = 1'b0;
   logic             RST = 1'b0;
   logic             START = 1'b0;
   logic             BYTE_VALID = 1'b0;
   logic [7:0]       BYTE_DATA = 8'h00;
   logic             WE;
   logic [WIDTH-1:0] WADDR;
   logic [WIDTH-1:0] WDATA;
   logic             CPU_HOLD;
   logic             BUSY;
   logic             DONE;
   logic             ERROR;

   instr_mem_loader #(.WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .BYTE_VALID (BYTE_VALID),
      .BYTE_DATA  (BYTE_DATA),
      .WE         (WE),
      .WADDR      (WADDR),
      .WDATA      (WDATA),
      .CPU_HOLD   (CPU_HOLD),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERROR      (ERROR)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   wr_t        exp_q[$];
   logic [7:0] stim[$];
   int         we_cyc[$];

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge CLK) begin
      if (RST) begin
         if (WE) begin
            wr_t e;
            we_cyc.push_back(cyc);
            check("we_under_hold", 64'(CPU_HOLD), 64'd1);
            check("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("waddr", 64'(WADDR), 64'(e.addr));
               check("wdata", 64'(WDATA), 64'(e.data));
            end
         end
         if (DONE) done_cnt++;
      end
   end

   // Reference model: decode the whole stream, returns 1 if it should end in ERR.
   task automatic model_load(output int kind, output int n);
      wr_t e;
      n = int'(stim[0]) + 256 * int'(stim[1]);
      if (n > MEM_DEPTH) begin
         kind = 1;
      end else begin
         kind = 0;
         for (int w = 0; w < n; w++) begin
            e.addr = 32'(4 * w);
            e.data = {stim[2+4*w+3], stim[2+4*w+2], stim[2+4*w+1], stim[2+4*w]};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      BYTE_VALID = 1'b1;
      BYTE_DATA  = b;
      @(posedge CLK);
      #1;
      BYTE_VALID = 1'b0;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   task automatic build(input int n);
      logic [15:0] len;
      len = 16'(n);
      stim.delete();
      stim.push_back(len[7:0]);
      stim.push_back(len[15:8]);
      for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(255, 0)));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"},    64'(WE),       64'd0);
      check({tag, "_waddr"}, 64'(WADDR),    64'd0);
      check({tag, "_wdata"}, 64'(WDATA),    64'd0);
      check({tag, "_hold"},  64'(CPU_HOLD), 64'd0);
      check({tag, "_busy"},  64'(BUSY),     64'd0);
      check({tag, "_done"},  64'(DONE),     64'd0);
      check({tag, "_error"}, 64'(ERROR),    64'd0);
   endtask

   task automatic run_load(input int max_gap, input bit mid_start);
      int kind, n, d0, t;
      model_load(kind, n);
      d0 = done_cnt;
      pulse_start();
      check("hold_after_start", 64'(CPU_HOLD), 64'd1);
      check("busy_after_start", 64'(BUSY), 64'd1);
      for (int i = 0; i < stim.size(); i++) begin
         idle(int'($urandom_range(max_gap, 0)));
         if (mid_start && i == 6) pulse_start();
         send_byte(stim[i]);
         if (kind == 0 && i >= 2 && (i - 2) % 4 == 3) check("we_latency", 64'(WE), 64'd1);
      end
      if (kind == 1) begin
         check("error_set", 64'(ERROR), 64'd1);
         check("error_not_busy", 64'(BUSY), 64'd0);
         check("error_hold", 64'(CPU_HOLD), 64'd1);
      end else begin
         if (n > 0) begin
            check("done_after_last_we", 64'(DONE), 64'd0);
            idle(1);
         end
         check("done_timing", 64'(DONE), 64'd1);
         check("hold_in_done", 64'(CPU_HOLD), 64'd1);
         t = 0;
         while (done_cnt == d0 && t < 10) begin
            idle(1);
            t++;
         end
         check("done_seen", 64'(done_cnt - d0), 64'd1);
         check("writes_drained", 64'(exp_q.size()), 64'd0);
         check("hold_released", 64'(CPU_HOLD), 64'd0);
         check("idle_not_busy", 64'(BUSY), 64'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check_all_zero("reset");
      RST = 1'b1;
      idle(2);

      // Basic two-word load
      stim = {8'h02, 8'h00, 8'h93, 8'h00, 8'ha0, 8'h01, 8'ha3, 8'h20, 8'h10, 8'h50};
      run_load(0, 1'b0);

      // Empty load
      stim = {8'h00, 8'h00};
      run_load(2, 1'b0);

      // Over-length, then bytes ignored, then recovery through START
      stim = {8'h01, 8'h01};
      run_load(0, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(255, 0)));
      idle(2);
      check("error_holds", 64'(ERROR), 64'd1);
      check("error_no_writes", 64'(exp_q.size()), 64'd0);
      stim = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
      run_load(1, 1'b0);
      check("error_cleared", 64'(ERROR), 64'd0);

      // Back-to-back data bytes
      we_cyc.delete();
      build(2);
      run_load(0, 1'b0);
      check("b2b_we_count", 64'(we_cyc.size()), 64'd2);
      if (we_cyc.size() == 2) check("b2b_spacing", 64'(we_cyc[1] - we_cyc[0]), 64'd4);

      // Reset after two of four data bytes
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      RST = 1'b0;
      #1;
      check_all_zero("midreset");
      idle(2);
      RST = 1'b1;
      idle(2);
      send_byte(8'h33);
      send_byte(8'h44);
      idle(3);
      check("midreset_stays_idle", 64'(BUSY), 64'd0);
      check("midreset_no_hold", 64'(CPU_HOLD), 64'd0);

      // START during DATA has no effect on addressing
      build(3);
      run_load(1, 1'b1);

      // Largest legal load
      build(MEM_DEPTH);
      run_load(0, 1'b0);

      // Randomised loads
      for (int k = 0; k < 10; k++) begin
         build(int'($urandom_range(5, 1)));
         run_load(int'($urandom_range(3, 0)), 1'b0);
      end

      idle(5);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
